// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline constants and forwarding select codes
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int SEL_W      = 2;

  // The EX operand muxes decode these same constants; 2'b11 is never produced.
  localparam logic [SEL_W-1:0] FWD_BUS = 2'b00;
  localparam logic [SEL_W-1:0] FWD_WB  = 2'b01;
  localparam logic [SEL_W-1:0] FWD_ALU = 2'b10;

endpackage

// File: rtl/ex_forward_ctrl_if.sv
// rtl/ex_forward_ctrl_if.sv - ID-side request and EX forwarding/stall response bundle
interface ex_forward_ctrl_if;
  import mips_pkg::*;

  logic                  i_halt;
  logic                  i_flush;
  logic [REG_ADDR_W-1:0] i_id_rs;
  logic [REG_ADDR_W-1:0] i_id_rt;
  logic                  i_id_uses_rs;
  logic                  i_id_uses_rt;
  logic [REG_ADDR_W-1:0] i_id_wb_addr;
  logic                  i_id_reg_write;
  logic                  i_id_mem_read;
  logic [SEL_W-1:0]      o_src_A_select;
  logic [SEL_W-1:0]      o_src_B_select;
  logic                  o_stall;
  logic [REG_ADDR_W-1:0] o_ex_wb_addr;
  // WB-stage shadow, visible for debug only
  logic                  o_wb_we;
  logic [REG_ADDR_W-1:0] o_wb_addr;

  modport slave (
    input  i_halt, i_flush, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
           i_id_wb_addr, i_id_reg_write, i_id_mem_read,
    output o_src_A_select, o_src_B_select, o_stall, o_ex_wb_addr, o_wb_we, o_wb_addr
  );

  modport master (
    output i_halt, i_flush, i_id_rs, i_id_rt, i_id_uses_rs, i_id_uses_rt,
           i_id_wb_addr, i_id_reg_write, i_id_mem_read,
    input  o_src_A_select, o_src_B_select, o_stall, o_ex_wb_addr, o_wb_we, o_wb_addr
  );

endinterface

// File: rtl/ex_forward_ctrl_fwd_sel_cmp.sv
// rtl/ex_forward_ctrl_fwd_sel_cmp.sv - one-operand forwarding priority comparator
module fwd_sel_cmp
  import mips_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  uses,
  input  logic                  ex_we,
  input  logic [REG_ADDR_W-1:0] ex_addr,
  input  logic                  mem_we,
  input  logic [REG_ADDR_W-1:0] mem_addr,
  output logic [SEL_W-1:0]      sel
);

  logic live;

  // $0 is hardwired, so a write to it never produces a forwardable value.
  assign live = uses && (src != '0);

  always_comb begin
    sel = FWD_BUS;
    if (live && ex_we && (ex_addr == src)) begin
      sel = FWD_ALU;
    end else if (live && mem_we && (mem_addr == src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/ex_forward_ctrl.sv
// rtl/ex_forward_ctrl.sv - EX operand forwarding select and load-use stall generator
module ex_forward_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int SEL_W      = 2
) (
  input logic              i_clk,
  input logic              i_rst_n,
  ex_forward_ctrl_if.slave bus
);
  import mips_pkg::FWD_BUS;

  logic                  ex_we, ex_ld, mem_we, wb_we;
  logic [REG_ADDR_W-1:0] ex_addr, mem_addr, wb_addr;
  logic [SEL_W-1:0]      sel_a_q, sel_b_q, sel_a_d, sel_b_d;
  logic                  hazard, stall, bubble;

  fwd_sel_cmp u_cmp_rs (
    .src      (bus.i_id_rs),
    .uses     (bus.i_id_uses_rs),
    .ex_we    (ex_we),
    .ex_addr  (ex_addr),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .sel      (sel_a_d)
  );

  fwd_sel_cmp u_cmp_rt (
    .src      (bus.i_id_rt),
    .uses     (bus.i_id_uses_rt),
    .ex_we    (ex_we),
    .ex_addr  (ex_addr),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .sel      (sel_b_d)
  );

  // A load in EX has no data yet; one bubble moves it to MEM where WB forwarding covers it.
  assign hazard = ex_we && ex_ld && (ex_addr != '0) &&
                  ((bus.i_id_uses_rs && (bus.i_id_rs == ex_addr)) ||
                   (bus.i_id_uses_rt && (bus.i_id_rt == ex_addr)));
  assign stall  = hazard && !bus.i_halt;
  assign bubble = stall || bus.i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ex_we    <= 1'b0;
      ex_ld    <= 1'b0;
      ex_addr  <= '0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      wb_we    <= 1'b0;
      wb_addr  <= '0;
      sel_a_q  <= FWD_BUS;
      sel_b_q  <= FWD_BUS;
    end else if (!bus.i_halt) begin
      wb_we    <= mem_we;
      wb_addr  <= mem_addr;
      mem_we   <= ex_we;
      mem_addr <= ex_addr;
      if (bubble) begin
        ex_we   <= 1'b0;
        ex_ld   <= 1'b0;
        ex_addr <= '0;
        sel_a_q <= FWD_BUS;
        sel_b_q <= FWD_BUS;
      end else begin
        ex_we   <= bus.i_id_reg_write;
        ex_ld   <= bus.i_id_mem_read;
        ex_addr <= bus.i_id_wb_addr;
        sel_a_q <= sel_a_d;
        sel_b_q <= sel_b_d;
      end
    end
  end

  assign bus.o_src_A_select = sel_a_q;
  assign bus.o_src_B_select = sel_b_q;
  assign bus.o_stall        = stall;
  assign bus.o_ex_wb_addr   = ex_addr;
  assign bus.o_wb_we        = wb_we;
  assign bus.o_wb_addr      = wb_addr;

endmodule

// File: tb/tb_ex_forward_ctrl.sv
// tb/tb_ex_forward_ctrl.sv - directed self-checking bench for ex_forward_ctrl
module tb_ex_forward_ctrl;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_failed;

  ex_forward_ctrl_if bus ();

  ex_forward_ctrl #(.REG_ADDR_W(5), .SEL_W(2)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                       input logic [4:0] wb, input logic rw, input logic mr);
    bus.i_id_rs        = rs;
    bus.i_id_rt        = rt;
    bus.i_id_uses_rs   = urs;
    bus.i_id_uses_rt   = urt;
    bus.i_id_wb_addr   = wb;
    bus.i_id_reg_write = rw;
    bus.i_id_mem_read  = mr;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    rst_n    = 1'b0;
    bus.i_halt  = 1'b0;
    bus.i_flush = 1'b0;
    issue(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    chk("reset_sel_a", 32'(bus.o_src_A_select), 32'd0);
    chk("reset_sel_b", 32'(bus.o_src_B_select), 32'd0);
    chk("reset_stall", 32'(bus.o_stall), 32'd0);
    chk("reset_ex_addr", 32'(bus.o_ex_wb_addr), 32'd0);
    rst_n = 1'b1;
    tick();

    // back-to-back ALU dependency on rs
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
    tick();
    chk("b2b_ex_addr", 32'(bus.o_ex_wb_addr), 32'd10);
    issue(5'd10, 5'd3, 1'b1, 1'b1, 5'd11, 1'b1, 1'b0);
    chk("b2b_no_stall", 32'(bus.o_stall), 32'd0);
    tick();
    chk("b2b_sel_a", 32'(bus.o_src_A_select), 32'd2);
    chk("b2b_sel_b", 32'(bus.o_src_B_select), 32'd0);

    // distance-2 dependency on rt
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd15, 1'b1, 1'b0);
    tick();
    issue(5'd4, 5'd5, 1'b1, 1'b1, 5'd16, 1'b1, 1'b0);
    tick();
    issue(5'd6, 5'd15, 1'b1, 1'b1, 5'd17, 1'b1, 1'b0);
    tick();
    chk("dist2_sel_b", 32'(bus.o_src_B_select), 32'd1);
    chk("dist2_sel_a", 32'(bus.o_src_A_select), 32'd0);

    // double hit: EX beats MEM
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0);
    tick();
    issue(5'd7, 5'd3, 1'b1, 1'b1, 5'd18, 1'b1, 1'b0);
    tick();
    chk("double_sel_a", 32'(bus.o_src_A_select), 32'd2);
    chk("double_sel_b", 32'(bus.o_src_B_select), 32'd0);

    // load-use: one stall cycle, bubble, then WB forward
    issue(5'd1, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1);
    tick();
    issue(5'd8, 5'd9, 1'b1, 1'b1, 5'd12, 1'b1, 1'b0);
    #1;
    chk("lu_stall", 32'(bus.o_stall), 32'd1);
    tick();
    chk("lu_bubble_addr", 32'(bus.o_ex_wb_addr), 32'd0);
    chk("lu_bubble_sel_a", 32'(bus.o_src_A_select), 32'd0);
    chk("lu_stall_released", 32'(bus.o_stall), 32'd0);
    tick();
    chk("lu_sel_a", 32'(bus.o_src_A_select), 32'd1);
    chk("lu_sel_b", 32'(bus.o_src_B_select), 32'd0);
    chk("lu_ex_addr", 32'(bus.o_ex_wb_addr), 32'd12);

    // load to $0 never stalls or forwards
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1);
    tick();
    issue(5'd0, 5'd0, 1'b1, 1'b1, 5'd19, 1'b1, 1'b0);
    #1;
    chk("zero_no_stall", 32'(bus.o_stall), 32'd0);
    tick();
    chk("zero_sel_a", 32'(bus.o_src_A_select), 32'd0);
    chk("zero_sel_b", 32'(bus.o_src_B_select), 32'd0);

    // rt not used: no forward despite match
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd20, 1'b1, 1'b0);
    tick();
    issue(5'd1, 5'd20, 1'b1, 1'b0, 5'd21, 1'b1, 1'b0);
    tick();
    chk("nouse_sel_b", 32'(bus.o_src_B_select), 32'd0);
    chk("nouse_sel_a", 32'(bus.o_src_A_select), 32'd0);

    // halt freezes outputs for three cycles
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd22, 1'b1, 1'b0);
    tick();
    issue(5'd22, 5'd3, 1'b1, 1'b1, 5'd23, 1'b1, 1'b0);
    tick();
    chk("pre_halt_sel_a", 32'(bus.o_src_A_select), 32'd2);
    bus.i_halt = 1'b1;
    issue(5'd23, 5'd23, 1'b1, 1'b1, 5'd24, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("halt_sel_a", 32'(bus.o_src_A_select), 32'd2);
      chk("halt_sel_b", 32'(bus.o_src_B_select), 32'd0);
      chk("halt_ex_addr", 32'(bus.o_ex_wb_addr), 32'd23);
    end
    bus.i_halt = 1'b0;

    // flush squashes a pending dependency
    issue(5'd1, 5'd2, 1'b1, 1'b1, 5'd25, 1'b1, 1'b0);
    tick();
    issue(5'd25, 5'd25, 1'b1, 1'b1, 5'd26, 1'b1, 1'b0);
    bus.i_flush = 1'b1;
    tick();
    bus.i_flush = 1'b0;
    chk("flush_sel_a", 32'(bus.o_src_A_select), 32'd0);
    chk("flush_sel_b", 32'(bus.o_src_B_select), 32'd0);
    chk("flush_ex_addr", 32'(bus.o_ex_wb_addr), 32'd0);

    // halt masks stall, then async reset mid-stall
    issue(5'd1, 5'd27, 1'b1, 1'b0, 5'd27, 1'b1, 1'b1);
    tick();
    issue(5'd27, 5'd3, 1'b1, 1'b1, 5'd28, 1'b1, 1'b0);
    bus.i_halt = 1'b1;
    #1;
    chk("halt_masks_stall", 32'(bus.o_stall), 32'd0);
    bus.i_halt = 1'b0;
    #1;
    chk("rst_pre_stall", 32'(bus.o_stall), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_stall", 32'(bus.o_stall), 32'd0);
    chk("rst_sel_a", 32'(bus.o_src_A_select), 32'd0);
    chk("rst_sel_b", 32'(bus.o_src_B_select), 32'd0);
    chk("rst_ex_addr", 32'(bus.o_ex_wb_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule

// File: doc/ex_forward_ctrl.md
Name: ex_forward_ctrl

Overview:
- Producer side of the EX-stage operand-forwarding interface. It generates the registered 2-bit `src_A_select` / `src_B_select` codes that steer the EX operand muxes.
- It also raises the load-use stall request toward IF/ID.
- It keeps its own shadow of the destination registers in flight in EX, MEM and WB. The codes are computed while the consumer sits in ID and are registered as the consumer enters EX.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- SEL_W, 2, width of forwarding select codes.

Ports:
- i_clk  in  1  pipeline clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_halt  in  1  global freeze; all state holds.
- i_flush  in  1  squash the ID instruction (taken branch/jump); a bubble enters EX.
- i_id_rs  in  REG_ADDR_W  rs field of the instruction in ID.
- i_id_rt  in  REG_ADDR_W  rt field of the instruction in ID.
- i_id_uses_rs  in  1  ID instruction reads rs.
- i_id_uses_rt  in  1  ID instruction reads rt.
- i_id_wb_addr  in  REG_ADDR_W  resolved destination of the ID instruction (rt, rd or 31).
- i_id_reg_write  in  1  ID instruction writes the register file.
- i_id_mem_read  in  1  ID instruction is a load.
- o_src_A_select  out  SEL_W  EX operand A source for the instruction now in EX.
- o_src_B_select  out  SEL_W  EX operand B source for the instruction now in EX.
- o_stall  out  1  load-use hazard; hold PC and IF/ID, bubble ID/EX (combinational).
- o_ex_wb_addr  out  REG_ADDR_W  destination tracked for the EX instruction (debug/verification).

Behaviour:
- Select encoding, fixed:
  - 2'b00: register bus.
  - 2'b01: forwarded WB result (MEM/WB).
  - 2'b10: forwarded ALU result (EX/MEM).
  - 2'b11: never driven.
- Shadow stages: ex_{we,ld,addr}, mem_{we,addr}, wb_{we,addr}.
- Each un-halted rising edge advances the stages:
  - wb takes mem.
  - mem takes ex (we, addr).
  - ex takes the ID fields, or a bubble (we=0, ld=0, addr=0) if o_stall or i_flush.
- Select computation, same edge, for operand X in {rs, rt}; evaluated with pre-edge shadow values:
  - If uses_X, X≠0, ex_we and ex_addr==X: 2'b10.
  - Else if uses_X, X≠0, mem_we and mem_addr==X: 2'b01.
  - Else: 2'b00.
  - EX match always beats MEM match.
- On a stall or flush edge, both selects load 2'b00.
- o_stall = ex_we & ex_ld & ex_addr≠0 & ((i_id_uses_rs & i_id_rs==ex_addr) | (i_id_uses_rt & i_id_rt==ex_addr)).
- Stall length is exactly one cycle. After the bubble the load sits in MEM, so the consumer resolves to 2'b01.
- o_stall is masked (0) while i_halt=1.
- i_flush and a stall in the same cycle: a single bubble is inserted; o_stall still asserts.
- The register file is write-first, so the WB-to-ID distance needs no forwarding; there is no 3rd comparison level.
- i_halt=1: no shadow or select register changes; outputs hold.
- Reset, asynchronous, any time including mid-stall:
  - All shadows are cleared to 0.
  - o_src_A_select = o_src_B_select = 2'b00.
  - o_ex_wb_addr = 0.
  - o_stall = 0 as a consequence of the cleared shadows.
- Latency: selects are valid in the same cycle the instruction is in EX (1 clock after ID).

Decomposition:
- Shared package `mips_pkg`: the select codes FWD_BUS=2'b00, FWD_WB=2'b01, FWD_ALU=2'b10, plus REG_ADDR_W. The EX operand muxes import the same constants.
- One natural sub-module, `fwd_sel_cmp`: a combinational priority comparator for one operand, instantiated twice (rs and rt).
- Shadow pipeline and stall logic stay in the top.

Test Plan:
1. Back-to-back ALU dependency:
   - `add $10,..` then `sub ..,$10,$3`.
   - Consumer in EX: o_src_A_select=2'b10, o_src_B_select=2'b00, no stall.
2. Distance-2 dependency:
   - Producer writes $15, one independent instruction, then a consumer reading $15 as rt.
   - Consumer in EX: o_src_B_select=2'b01.
3. Double hit:
   - Producers both write $7 at distance 1 and 2; consumer reads $7 on rs.
   - A select=2'b10 (EX wins).
4. Load-use:
   - `lw $8` followed by a consumer using $8.
   - o_stall=1 for exactly 1 cycle, bubble observed (o_ex_wb_addr=0).
   - Consumer then enters EX with select=2'b01.
5. $0 / no-use:
   - Producer writes $0, or the consumer has uses_rt=0.
   - Selects stay 2'b00 and o_stall stays 0, even after a load to $0.
6. Halt, flush, reset:
   - i_halt: outputs frozen for 3 cycles.
   - i_flush with a pending dependency: selects 2'b00.
   - i_rst_n pulsed low mid-stall: o_stall drops immediately and all outputs read 0.
